kf76489_bus_control: RTL and testbench
======================================

KF76489_BUS_CONTROL -- requirements
Module: kf76489_bus_control

Interface
REQ-001 SHALL have parameter READY_CYCLES, default 32: number of clock_enable pulses that ready stays low after each accepted write.
REQ-002 SHALL have these ports, each as name  direction  width  meaning:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- clock_enable  input  1  chip-rate tick, shared with the tone generators.
- chip_enable_n  input  1  CPU chip select, active low.
- write_enable_n  input  1  CPU write strobe, active low.
- data_bus  input  8  CPU data byte, CPU bit order.
- ready  output  1  1 = able to accept a write; 0 = busy.
- internal_data_bus  output  8  bit-reversed copy of the captured byte.
- write_frequency_h  output  3  per-tone-channel strobe (channels 0-2) for frequency nibble F3..F0.
- write_frequency_l  output  3  per-tone-channel strobe (channels 0-2) for frequency bits F9..F4.
- write_attenuation  output  4  per-channel attenuation strobe (channels 0-3).
- write_noise  output  1  noise-control strobe.

Function
REQ-003 SHALL detect a write request at the rising edge where chip_enable_n=0, write_enable_n=0, ready=1 and the block is armed.
REQ-004 SHALL disarm after each accepted write and re-arm only after it samples chip_enable_n=1 or write_enable_n=1.
REQ-005 SHALL use FSM states IDLE, STROBE, BUSY and transition as follows:
- IDLE -> STROBE on a detected request, capturing data_bus.
- STROBE -> BUSY after exactly one cycle.
- BUSY -> IDLE after READY_CYCLES clock_enable pulses are counted.
REQ-006 SHALL drive internal_data_bus[i] = captured[7-i] from the STROBE cycle onward, holding it until the next capture.
REQ-007 SHALL treat a captured byte with bit7=1 as a latch byte, decoded as follows:
- channel = bits6:5; type = bit4 (0 = frequency/noise, 1 = attenuation).
- Both fields are stored in internal latch registers.
REQ-008 SHALL, in STROBE for a latch byte, assert exactly one strobe for one cycle:
- write_attenuation[ch] if type=1.
- write_noise if ch=3 and type=0.
- Otherwise write_frequency_h[ch].
REQ-009 SHALL treat a captured byte with bit7=0 as a data byte that uses the stored channel and type, and SHALL, in STROBE, assert exactly one strobe for one cycle:
- write_attenuation[ch] if type=1.
- write_noise if ch=3 and type=0.
- Otherwise write_frequency_l[ch].
REQ-010 SHALL keep all strobes zero in every state except STROBE, with at most one strobe bit high in any cycle.
REQ-011 SHALL drive ready=0 from the STROBE cycle until the BUSY->IDLE transition, and ready=1 in the following cycle.
REQ-012 SHALL count clock_enable pulses in BUSY with a counter of width clog2(READY_CYCLES+1) that does not wrap; a clock_enable in the STROBE cycle is not counted.
REQ-013 SHALL ignore data_bus, chip_enable_n and write_enable_n while ready=0: no capture, no strobe, and no change to the latch registers.
REQ-014 SHALL, when ready rises while the CPU still holds chip_enable_n=0 and write_enable_n=0, not re-trigger until a release is sampled (REQ-004).
REQ-015 SHALL accept a data byte before any latch byte, using the reset latch (channel 0, frequency), and assert write_frequency_l[0].

Reset
REQ-016 SHALL, on reset=0 at a rising edge, set the following, with effect the cycle after that edge:
- FSM = IDLE; ready = 1; armed = 1.
- All strobes = 0; internal_data_bus = 8'h00.
- Latched channel = 0, type = 0; counter = 0.
REQ-017 SHALL abort any in-progress STROBE or BUSY on reset with no further strobe, then obey REQ-016.

Verification
REQ-018 Bench SHALL cover latch byte 8'h8A (chip_enable_n=write_enable_n=0 for 2 cycles) -> the following:
- write_frequency_h=3'b001 for 1 cycle.
- internal_data_bus=8'h51.
- ready low for 32 clock_enable pulses, then high.
REQ-019 Bench SHALL cover, after REQ-018, data byte 8'h00 -> write_frequency_l=3'b001 for 1 cycle and internal_data_bus=8'h00, then 8'h3F -> internal_data_bus=8'hFC.
REQ-020 Bench SHALL cover latch byte 8'hF5 -> write_attenuation=4'b1000 for 1 cycle and internal_data_bus=8'hAF; a following data byte 8'h03 -> write_attenuation=4'b1000 and internal_data_bus=8'hC0.
REQ-021 Bench SHALL cover latch byte 8'hE4 -> write_noise for 1 cycle; a second write pulse issued while ready=0 -> no strobe and latch unchanged.
REQ-022 Bench SHALL cover write_enable_n held low for 100 clock_enable pulses -> exactly one strobe, and ready high after 32 pulses with no re-trigger.
REQ-023 Bench SHALL cover reset=0 asserted during BUSY -> the next cycle has ready=1 and all strobes 0; a subsequent 8'h00 data byte -> write_frequency_l=3'b001.

Source files
------------

// File: rtl/kf76489_bus_control.sv
// kf76489_bus_control: CPU write port of the tone chip, capturing a byte,
// decoding it into per-channel register strobes and holding off for READY_CYCLES ticks.
module kf76489_bus_control #(
  parameter int READY_CYCLES = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_enable,
  input  logic       chip_enable_n,
  input  logic       write_enable_n,
  input  logic [7:0] data_bus,
  output logic       ready,
  output logic [7:0] internal_data_bus,
  output logic [2:0] write_frequency_h,
  output logic [2:0] write_frequency_l,
  output logic [3:0] write_attenuation,
  output logic       write_noise
);
  localparam int CW = $clog2(READY_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, STROBE, BUSY} state_t;
  state_t        state_q, state_d;
  logic          armed_q, armed_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    chan_q, chan_d;
  logic          type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req, done, stb;
  logic [3:0]    ch_oh;
  assign req  = state_q == IDLE && !chip_enable_n && !write_enable_n && armed_q;
  assign done = clock_enable && int'(cnt_q) + 1 >= READY_CYCLES;
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE   ? (req ? STROBE : IDLE) :
              state_q == STROBE ? BUSY :
              state_q == BUSY   ? (done ? IDLE : BUSY) : IDLE;
  end
  // Latch fields only follow latch bytes; data bytes reuse the stored channel/type.
  always_comb begin
    armed_d = req ? 1'b0 : (chip_enable_n || write_enable_n) ? 1'b1 : armed_q;
    data_d  = req ? data_bus : data_q;
    chan_d  = req && data_bus[7] ? data_bus[6:5] : chan_q;
    type_d  = req && data_bus[7] ? data_bus[4] : type_q;
    cnt_d   = state_q != BUSY || done ? '0 :
              clock_enable && cnt_q != CW'(READY_CYCLES) ? cnt_q + CW'(1) : cnt_q;
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      armed_q <= 1'b1;
      data_q  <= 8'h00;
      chan_q  <= 2'd0;
      type_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      armed_q <= armed_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end
  assign stb   = state_q == STROBE;
  assign ch_oh = 4'b0001 << chan_q;
  always_comb begin
    ready             = state_q == IDLE;
    internal_data_bus = {<<{data_q}};
    write_attenuation = stb && type_q ? ch_oh : 4'b0000;
    write_noise       = stb && !type_q && chan_q == 2'd3;
    write_frequency_h = stb && !type_q && chan_q != 2'd3 && data_q[7] ? ch_oh[2:0] : 3'b000;
    write_frequency_l = stb && !type_q && chan_q != 2'd3 && !data_q[7] ? ch_oh[2:0] : 3'b000;
  end
endmodule

// File: tb/tb_kf76489_bus_control.sv
// tb_kf76489_bus_control: scoreboard bench; writes push expected strobe/bus pairs,
// a negedge monitor pops them on every strobe and times each ready-low window.
module tb_kf76489_bus_control;
  logic       clock = 0, reset = 0, clock_enable = 0, chip_enable_n = 1, write_enable_n = 1;
  logic [7:0] data_bus = 8'h00;
  logic       ready, write_noise;
  logic [7:0] internal_data_bus;
  logic [2:0] write_frequency_h, write_frequency_l;
  logic [3:0] write_attenuation;
  int errors = 0, checks = 0;
  typedef struct {logic [10:0] stb; logic [7:0] idb;} exp_t;
  exp_t q[$];
  bit started = 0;

  kf76489_bus_control #(.READY_CYCLES(32)) dut (
    .clock(clock), .reset(reset), .clock_enable(clock_enable),
    .chip_enable_n(chip_enable_n), .write_enable_n(write_enable_n), .data_bus(data_bus),
    .ready(ready), .internal_data_bus(internal_data_bus),
    .write_frequency_h(write_frequency_h), .write_frequency_l(write_frequency_l),
    .write_attenuation(write_attenuation), .write_noise(write_noise));

  always #5 clock = ~clock;

  initial begin
    int cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      clock_enable = cyc % 3 == 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [2:0] fh, input logic [2:0] fl, input logic [3:0] att,
                           input logic n, input logic [7:0] idb);
    exp_t e;
    e.stb = {fh, fl, att, n};
    e.idb = idb;
    q.push_back(e);
  endtask

  task automatic write(input logic [7:0] d, input int hold);
    @(posedge clock);
    #1;
    data_bus = d;
    chip_enable_n = 0;
    write_enable_n = 0;
    repeat (hold) @(posedge clock);
    #1;
    chip_enable_n = 1;
    write_enable_n = 1;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    @(negedge clock);
    while (ready !== 1'b1 && t < 2000) begin
      @(negedge clock);
      t++;
    end
    chk(name, {31'd0, ready}, 32'd1);
  endtask

  // Scoreboard monitor plus ready-window pulse counter (the STROBE cycle tick is not counted).
  always @(negedge clock) begin
    logic [10:0] s;
    exp_t e;
    static bit prev_ready = 1, abort = 0;
    static int pulses = 0;
    s = {write_frequency_h, write_frequency_l, write_attenuation, write_noise};
    if (started) begin
      if (s !== 11'd0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe got=%b expected=none", s);
        end else begin
          e = q.pop_front();
          chk("strobe", {21'd0, s}, {21'd0, e.stb});
          chk("idb", {24'd0, internal_data_bus}, {24'd0, e.idb});
        end
      end
      if (!reset) abort = 1;
      if (ready === 1'b0) begin
        if (prev_ready) begin
          pulses = 0;
          abort = !reset;
        end else if (clock_enable) pulses++;
      end else if (!prev_ready) begin
        if (!abort) chk("ready_low_pulses", pulses, 32);
        abort = 0;
      end
      prev_ready = ready !== 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_idb", {24'd0, internal_data_bus}, 32'd0);
    chk("rst_strobes", {21'd0, write_frequency_h, write_frequency_l, write_attenuation, write_noise}, 32'd0);
    started = 1;
    @(posedge clock);
    #1;
    reset = 1;
    expect_wr(3'b001, 3'b000, 4'b0000, 0, 8'h51);
    write(8'h8A, 2);
    wait_ready("ready_8A");
    expect_wr(3'b000, 3'b001, 4'b0000, 0, 8'h00);
    write(8'h00, 2);
    wait_ready("ready_00");
    expect_wr(3'b000, 3'b001, 4'b0000, 0, 8'hFC);
    write(8'h3F, 2);
    wait_ready("ready_3F");
    expect_wr(3'b000, 3'b000, 4'b1000, 0, 8'hAF);
    write(8'hF5, 2);
    wait_ready("ready_F5");
    expect_wr(3'b000, 3'b000, 4'b1000, 0, 8'hC0);
    write(8'h03, 2);
    wait_ready("ready_03");
    expect_wr(3'b000, 3'b000, 4'b0000, 1, 8'h27);
    write(8'hE4, 2);
    repeat (5) @(posedge clock);
    write(8'h90, 2);
    wait_ready("ready_E4");
    expect_wr(3'b000, 3'b000, 4'b0000, 1, 8'hA0);
    write(8'h05, 2);
    wait_ready("ready_05");
    expect_wr(3'b100, 3'b000, 4'b0000, 0, 8'h63);
    write(8'hC6, 300);
    chk("held_ready_high", {31'd0, ready}, 32'd1);
    wait_ready("ready_C6");
    expect_wr(3'b010, 3'b000, 4'b0000, 0, 8'hC5);
    write(8'hA3, 2);
    repeat (20) @(posedge clock);
    #1;
    reset = 0;
    @(posedge clock);
    #1;
    reset = 1;
    @(negedge clock);
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_strobes", {21'd0, write_frequency_h, write_frequency_l, write_attenuation, write_noise}, 32'd0);
    chk("abort_idb", {24'd0, internal_data_bus}, 32'd0);
    expect_wr(3'b000, 3'b001, 4'b0000, 0, 8'h00);
    write(8'h00, 2);
    wait_ready("ready_post_reset");
    repeat (3) @(negedge clock);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
